// File: rtl/bfp_pkg.sv
// Shared constants and helpers for the BFP decompressor.
//   COMP_METH_BFP : ctrl_ud_comp_meth value that selects block floating point
//   RB_SAMPLES    : samples per resource block
//   BEATS_PER_RB  : 4-sample output beats per resource block
//   byte_reverse  : converts network byte order (first byte in [7:0]) to an
//                   MSB-first word (first byte in [63:56]) and back
package bfp_pkg;
  localparam logic [3:0] COMP_METH_BFP = 4'd1;
  localparam int         RB_SAMPLES    = 24;
  localparam int         BEATS_PER_RB  = 6;

  function automatic logic [63:0] byte_reverse(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/bfp_bit_unpack.sv
// 128-bit MSB-first bit buffer between the input stream and the sample decoder.
//   in_data/in_valid/in_ready : 64-bit MSB-first beat in; ready while cnt <= 64 and not held
//   hold                      : blocks loading (packet tail draining)
//   need/ext                  : bits wanted by the decoder; ext high when cnt >= need,
//                               in which case those bits are consumed this cycle
//   flush                     : empties the buffer (pad bits at end of packet)
//   win                       : top 68 buffer bits, the largest extraction window
//   cnt                       : current fill count
module bfp_bit_unpack
  import bfp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  input  logic        hold,
  output logic        in_ready,
  input  logic [6:0]  need,
  input  logic        flush,
  output logic        ext,
  output logic [67:0] win,
  output logic [7:0]  cnt
);
  logic [127:0] bits_q, bits_n;
  logic [7:0]   cnt_q, cnt_n, cnt_mid;
  logic [6:0]   sh;
  logic         load;

  assign in_ready = (cnt_q <= 8'd64) && !hold;
  assign load     = in_valid && in_ready;
  assign ext      = cnt_q >= {1'b0, need};
  assign win      = bits_q[127:60];
  assign cnt      = cnt_q;

  // Bits below the valid region are always zero, so a new beat can be OR'd
  // in just after whatever survives this cycle's extraction.
  always_comb begin
    sh      = ext ? need : 7'd0;
    cnt_mid = cnt_q - {1'b0, sh};
    bits_n  = bits_q << sh;
    cnt_n   = cnt_mid;
    if (load) begin
      bits_n = bits_n | ({in_data, 64'd0} >> cnt_mid);
      cnt_n  = cnt_mid + 8'd64;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      bits_q <= bits_n;
      cnt_q  <= cnt_n;
    end
  end
endmodule

// File: rtl/bfp_decomp.sv
// Block-floating-point decompressor, 64-bit AXI-Stream in and out.
//   s_axis_* : compressed stream (tkeep ignored), tuser sampled on first beat
//   m_axis_* : four 16-bit samples per beat, tkeep constant 8'hFF, no backpressure
//   ctrl_ud_comp_meth / ctrl_ud_iq_width : mode and mantissa width, latched
//              only between packets
// Build option: BFP_DECOMP_EXP_CLAMP_EN clamps the exponent to 16-W so the
// shift cannot overflow; otherwise the shifted value is truncated to 16 bits.
module bfp_decomp
  import bfp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [31:0] s_axis_tuser,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [31:0] m_axis_tuser,
  input  logic [3:0]  ctrl_ud_comp_meth,
  input  logic [3:0]  ctrl_ud_iq_width
);
  logic [3:0]       meth_q, iqw_q, exp_q, exp_use, exp_eff;
  logic [2:0]       state_q;
  logic             last_in_q, in_pkt_q, first_out_q;
  logic [31:0]      pkt_user_q;
  logic             bfp, has_exp, load, ext, eop;
  logic [4:0]       w;
  logic [6:0]       need;
  logic [7:0]       cnt, rem;
  logic [8:0]       rb_bits;
  logic [67:0]      win;
  logic [63:0]      sa, tmp;
  logic signed [15:0] sx;
  logic [3:0][15:0] smp;
  logic             unused_ok;

  assign unused_ok    = &{1'b0, s_axis_tkeep};
  assign m_axis_tkeep = 8'hFF;

  assign bfp     = (meth_q == COMP_METH_BFP) && (iqw_q != 4'd0);
  assign w       = bfp ? {1'b0, iqw_q} : 5'd16;
  assign has_exp = bfp && (state_q == 3'd0);
  assign need    = (has_exp ? 7'd8 : 7'd0) + {w, 2'b00};
  assign load    = s_axis_tvalid && s_axis_tready;
  assign rem     = cnt - {1'b0, need};
  assign rb_bits = 9'd8 + 9'(RB_SAMPLES) * {4'd0, w};

  // Final beat of the packet: the tail left behind is too short to be another
  // RB (or another pass-through beat), so it is pad and gets flushed.
  assign eop = ext && last_in_q &&
               (bfp ? (state_q == 3'(BEATS_PER_RB - 1)) && ({1'b0, rem} < rb_bits)
                    : (rem < 8'd64));

  bfp_bit_unpack u_unpack (
    .clk      (clk),
    .rst      (rst),
    .in_data  (byte_reverse(s_axis_tdata)),
    .in_valid (s_axis_tvalid),
    .hold     (last_in_q),
    .in_ready (s_axis_tready),
    .need     (need),
    .flush    (eop),
    .ext      (ext),
    .win      (win),
    .cnt      (cnt)
  );

  // Samples sit MSB-first in sa; each is taken from the top 16 bits after
  // shifting, then an arithmetic right shift sign-extends the W-bit field.
  always_comb begin
    sa      = has_exp ? {win[59:0], 4'd0} : win[67:4];
    exp_use = has_exp ? win[63:60] : (bfp ? exp_q : 4'd0);
`ifdef BFP_DECOMP_EXP_CLAMP_EN
    exp_eff = ({1'b0, exp_use} > (5'd16 - w)) ? 4'(5'd16 - w) : exp_use;
`else
    exp_eff = exp_use;
`endif
    tmp = '0;
    sx  = '0;
    smp = '0;
    for (int i = 0; i < 4; i++) begin
      tmp    = sa << (i * int'(w));
      sx     = $signed(tmp[63:48]) >>> (5'd16 - w);
      smp[i] = sx <<< exp_eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meth_q        <= '0;
      iqw_q         <= '0;
      exp_q         <= '0;
      state_q       <= '0;
      last_in_q     <= 1'b0;
      in_pkt_q      <= 1'b0;
      first_out_q   <= 1'b1;
      pkt_user_q    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      if (!in_pkt_q) begin
        meth_q <= ctrl_ud_comp_meth;
        iqw_q  <= ctrl_ud_iq_width;
      end
      if (load) begin
        in_pkt_q <= 1'b1;
        if (!in_pkt_q)    pkt_user_q <= s_axis_tuser;
        if (s_axis_tlast) last_in_q  <= 1'b1;
      end
      m_axis_tvalid <= ext;
      m_axis_tlast  <= eop;
      if (ext) begin
        m_axis_tdata <= byte_reverse({smp[0], smp[1], smp[2], smp[3]});
        state_q      <= (state_q == 3'(BEATS_PER_RB - 1)) ? 3'd0 : state_q + 3'd1;
        if (has_exp) exp_q <= win[63:60];
        if (first_out_q) begin
          m_axis_tuser <= pkt_user_q;
          first_out_q  <= 1'b0;
        end
      end
      if (eop) begin
        state_q     <= '0;
        last_in_q   <= 1'b0;
        in_pkt_q    <= 1'b0;
        first_out_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bfp_decomp.sv
module tb_bfp_decomp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] s_axis_tuser = '0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast;
  logic [31:0] m_axis_tuser;
  logic [3:0]  ctrl_ud_comp_meth = '0;
  logic [3:0]  ctrl_ud_iq_width = '0;

  bfp_decomp dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .ctrl_ud_comp_meth(ctrl_ud_comp_meth), .ctrl_ud_iq_width(ctrl_ud_iq_width)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0, stall = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed output beats
  logic [63:0] oq_d[$];
  logic        oq_l[$];
  logic [31:0] oq_u[$];
  int          oq_c[$];
  // model: input beats, expected output beats, accept cycles
  logic [63:0] ib[$];
  logic [63:0] eb[$];
  int          acc_c[$];

  always @(negedge clk) begin
    if (m_axis_tvalid) begin
      oq_d.push_back(m_axis_tdata);
      oq_l.push_back(m_axis_tlast);
      oq_u.push_back(m_axis_tuser);
      oq_c.push_back(cyc);
    end
    if (s_axis_tvalid && !s_axis_tready) stall++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_out();
    oq_d.delete(); oq_l.delete(); oq_u.delete(); oq_c.delete();
  endtask

  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  // Reference decode: two's-complement W-bit value times 2^exp, low 16 bits.
  function automatic int dec(input int v, input int w, input int e);
    int sx, ee;
    sx = (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    ee = e;
`ifdef BFP_DECOMP_EXP_CLAMP_EN
    if (ee > 16 - w) ee = 16 - w;
`endif
    return (sx * (1 << ee)) & 32'hFFFF;
  endfunction

  // fs: -1 random samples, -2 alternating 8'h80/8'h01, else fixed value.
  task automatic build_bfp(input int w, input int nrb, input int fe, input int fs);
    bit          bits[$];
    int          s4[4];
    int          e, hi, v;
    logic [7:0]  eb8;
    logic [63:0] d;
    ib.delete(); eb.delete();
    for (int rb = 0; rb < nrb; rb++) begin
      e   = (fe < 0) ? int'($urandom_range(15)) : fe;
      hi  = int'($urandom_range(15));
      eb8 = {hi[3:0], e[3:0]};
      for (int b = 7; b >= 0; b--) bits.push_back(eb8[b]);
      for (int s = 0; s < 24; s++) begin
        if (fs == -1)      v = int'($urandom_range((1 << w) - 1));
        else if (fs == -2) v = (s % 2 == 0) ? 'h80 : 'h01;
        else               v = fs;
        for (int b = w - 1; b >= 0; b--) bits.push_back(v[b]);
        s4[s % 4] = dec(v, w, e);
        if (s % 4 == 3)
          eb.push_back({swap16(16'(s4[3])), swap16(16'(s4[2])),
                        swap16(16'(s4[1])), swap16(16'(s4[0]))});
      end
    end
    while (bits.size() % 64 != 0) bits.push_back(1'b0);
    for (int bt = 0; bt < bits.size() / 64; bt++) begin
      for (int k = 0; k < 8; k++)
        for (int b = 0; b < 8; b++) d[8*k + 7 - b] = bits[bt*64 + k*8 + b];
      ib.push_back(d);
    end
  endtask

  task automatic build_pt(input int n);
    ib.delete(); eb.delete();
    for (int i = 0; i < n; i++) begin
      ib.push_back({$urandom, $urandom});
      eb.push_back(ib[i]);
    end
  endtask

  task automatic set_ctrl(input int m, input int w);
    ctrl_ud_comp_meth = 4'(m);
    ctrl_ud_iq_width  = 4'(w);
    @(posedge clk); #1;
  endtask

  // Sends up to nmax beats of ib with tvalid held high throughout.
  task automatic send_pkt(input logic [31:0] user, input int nmax);
    logic r;
    int   n, c;
    acc_c.delete();
    for (int i = 0; i < ib.size() && i < nmax; i++) begin
      s_axis_tdata  = ib[i];
      s_axis_tlast  = (i == ib.size() - 1);
      s_axis_tuser  = (i == 0) ? user : $urandom;
      s_axis_tkeep  = 8'($urandom);
      s_axis_tvalid = 1'b1;
      n = 0;
      do begin
        r = s_axis_tready;
        c = cyc;
        @(posedge clk); #1;
        n++;
      end while (!r && n < 1000);
      if (!r) begin
        chk("send_timeout", {63'd0, r}, 64'd1);
        break;
      end
      acc_c.push_back(c);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic expect_pkt(input string tag, input logic [31:0] user);
    int n = 0;
    while (oq_d.size() < eb.size() && n < 3000) begin @(posedge clk); #1; n++; end
    repeat (20) @(posedge clk);
    #1;
    chk($sformatf("%s_nbeats", tag), 64'(oq_d.size()), 64'(eb.size()));
    for (int i = 0; i < eb.size() && i < oq_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), oq_d[i], eb[i]);
      chk($sformatf("%s_last%0d", tag, i), {63'd0, oq_l[i]}, {63'd0, i == eb.size() - 1});
      chk($sformatf("%s_user%0d", tag, i), {32'd0, oq_u[i]}, {32'd0, user});
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tready"}, {63'd0, s_axis_tready}, 64'd1);
    chk({tag, "_tvalid"}, {63'd0, m_axis_tvalid}, 64'd0);
    chk({tag, "_tlast"},  {63'd0, m_axis_tlast},  64'd0);
    chk({tag, "_tdata"},  m_axis_tdata, 64'd0);
    chk({tag, "_tuser"},  {32'd0, m_axis_tuser}, 64'd0);
    chk({tag, "_tkeep"},  {56'd0, m_axis_tkeep}, 64'hFF);
  endtask

  logic [31:0] u;
  logic [63:0] c35;
  int          w, nrb;

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // W=9 exp=2, 24 x 9'h0FF -> 6 beats of 16'h03FC
    set_ctrl(1, 9);
    clr_out();
    build_bfp(9, 1, 2, 'h0FF);
    chk("r031_nin", 64'(ib.size()), 64'd4);
    u = $urandom;
    send_pkt(u, 100);
    expect_pkt("r031", u);
    if (oq_d.size() > 0) chk("r031_const", oq_d[0], 64'hFC03_FC03_FC03_FC03);

    // W=8 exp=1, 8'h80 -> FF00, 8'h01 -> 0002
    set_ctrl(1, 8);
    clr_out();
    build_bfp(8, 1, 1, -2);
    u = $urandom;
    send_pkt(u, 100);
    expect_pkt("r032", u);
    if (oq_d.size() > 0) chk("r032_const", oq_d[0], 64'h0200_00FF_0200_00FF);

    // pass-through, latency 2
    set_ctrl(0, 5);
    clr_out();
    build_pt(3);
    u = $urandom;
    send_pkt(u, 100);
    expect_pkt("r033", u);
    for (int i = 0; i < 3 && i < oq_c.size() && i < acc_c.size(); i++)
      chk($sformatf("r033_lat%0d", i), 64'(oq_c[i] - acc_c[i]), 64'd2);

    // W=15, 10 RBs, tvalid held high: backpressure, 60 beats
    set_ctrl(1, 15);
    clr_out();
    build_bfp(15, 10, -1, -1);
    stall = 0;
    u = $urandom;
    send_pkt(u, 100);
    expect_pkt("r034", u);
    chk("r034_n60", 64'(oq_d.size()), 64'd60);
    chk("r034_stall", {63'd0, stall > 0}, 64'd1);

    // W=8 exp=12, 8'h7F: clamp vs truncate
    set_ctrl(1, 8);
    clr_out();
    build_bfp(8, 1, 12, 'h7F);
    u = $urandom;
    send_pkt(u, 100);
    expect_pkt("r035", u);
`ifdef BFP_DECOMP_EXP_CLAMP_EN
    c35 = {4{16'h007F}};
`else
    c35 = {4{16'h00F0}};
`endif
    if (oq_d.size() > 0) chk("r035_const", oq_d[0], c35);

    // randomized packets, mixed modes
    for (int k = 0; k < 6; k++) begin
      clr_out();
      if (k == 5) begin
        set_ctrl(1, 0);
        build_pt(int'($urandom_range(1, 5)));
      end else if (k % 3 == 2) begin
        set_ctrl(int'($urandom_range(2, 15)), int'($urandom_range(15)));
        build_pt(int'($urandom_range(1, 5)));
      end else begin
        w   = int'($urandom_range(2, 15));
        nrb = int'($urandom_range(1, 4));
        set_ctrl(1, w);
        build_bfp(w, nrb, -1, -1);
      end
      u = $urandom;
      send_pkt(u, 100);
      expect_pkt($sformatf("rnd%0d", k), u);
    end

    // reset mid-packet, then a clean W=9 packet
    set_ctrl(1, 9);
    build_bfp(9, 1, -1, -1);
    send_pkt($urandom, 2);
    rst = 1'b1;
    clr_out();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("r036_rst");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("r036_quiet", 64'(oq_d.size()), 64'd0);
    set_ctrl(1, 9);
    clr_out();
    build_bfp(9, 1, 2, 'h0FF);
    u = $urandom;
    send_pkt(u, 100);
    expect_pkt("r036", u);
    if (oq_d.size() > 0) chk("r036_const", oq_d[0], 64'hFC03_FC03_FC03_FC03);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
